// File: rtl/keypad_pkg.sv
// Shared constants, scan FSM states and key indexing for the keypad scanner.
// Imported by keypad_debounce and keypad_scan_debounce.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int KEYS = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int KW   = $clog2(KEYS);

  typedef enum logic {
    S_SCAN,
    S_FRAME
  } scan_state_t;

  // Bit position of the key at row r, column c.
  function automatic int key_idx(
    input int r,
    input int c
  );
    return r * COLS + c;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame assembly, frame-to-frame debounce, commit and press-pulse encode.
// Ports:
//   clk, rst       : clock, sync active-high reset
//   cap_en         : store cap_bits as row cap_row of the frame
//   cap_row        : row being captured
//   cap_bits       : active-high column bits for that row
//   frame_end      : one-cycle strobe, the frame is complete
//   key_state      : debounced key levels
//   key_pulse      : one-cycle mask of newly pressed keys
//   key_any        : any bit of key_pulse set
//   key_code       : index of lowest set key_pulse bit, 0 when none
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cap_en,
  input  logic [RW-1:0]   cap_row,
  input  logic [COLS-1:0] cap_bits,
  input  logic            frame_end,
  output logic [KEYS-1:0] key_state,
  output logic [KEYS-1:0] key_pulse,
  output logic            key_any,
  output logic [KW-1:0]   key_code
);

  localparam int CW =
    (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_FRAMES - 1);

  logic [KEYS-1:0] frame;
  logic [KEYS-1:0] prev_frame;
  logic [CW-1:0]   stable_cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            commit;

  // Counter saturates, so a long hold never wraps
  // back below the commit threshold.
  always_comb begin
    cnt_nxt = '0;
    if (frame == prev_frame) begin
      if (stable_cnt == CNT_MAX)
        cnt_nxt = CNT_MAX;
      else
        cnt_nxt = stable_cnt + CW'(1);
    end
    commit = frame_end && (cnt_nxt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame      <= '0;
      prev_frame <= '0;
      stable_cnt <= '0;
      key_state  <= '0;
      key_pulse  <= '0;
    end else begin
      key_pulse <= '0;
      for (int r = 0; r < ROWS; r++) begin
        if (cap_en && cap_row == RW'(r))
          frame[key_idx(r, 0) +: COLS] <= cap_bits;
      end
      if (frame_end) begin
        stable_cnt <= cnt_nxt;
        prev_frame <= frame;
        // Re-commit on every stable frame; only
        // 0->1 transitions pulse, so holds are quiet.
        if (commit) begin
          key_state <= frame;
          key_pulse <= frame & ~key_state;
        end
      end
    end
  end

  assign key_any = |key_pulse;

  always_comb begin
    key_code = '0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (key_pulse[i])
        key_code = KW'(i);
    end
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: row drive, column sync, debounced levels/pulses.
// Ports:
//   clk, rst  : clock, sync active-high reset
//   col       : active-low columns (async)
//   row       : active-low one-hot row drive, 4'b1111 idle
//   key_state : debounced levels, bit r*4+c
//   key_pulse : one-cycle mask of new presses
//   key_any   : |key_pulse
//   key_code  : lowest set key_pulse index, 0 when none
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 5000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row,
  output logic [KEYS-1:0] key_state,
  output logic [KEYS-1:0] key_pulse,
  output logic            key_any,
  output logic [KW-1:0]   key_code
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST =
    SW'(SCAN_DIV - 1);
  localparam logic [RW-1:0] ROW_LAST =
    RW'(ROWS - 1);

  scan_state_t     state;
  scan_state_t     state_nxt;
  logic [SW-1:0]   slot_cnt;
  logic [RW-1:0]   r;
  logic [COLS-1:0] col_meta;
  logic [COLS-1:0] col_sync;
  logic [ROWS-1:0] row_drv;
  logic            slot_last;
  logic            cap_en;
  logic            frame_end;

  logic [KEYS-1:0] ks;
  logic [KEYS-1:0] kp;
  logic            kany;
  logic [KW-1:0]   kcode;

  // Idle (all-high) columns mean no key.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  assign slot_last = (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_SCAN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    frame_end = 1'b0;
    row_drv   = '1;
    case (state)
      S_SCAN: begin
        row_drv = ~(ROWS'(1) << r);
        if (slot_last) begin
          cap_en = 1'b1;
          if (r == ROW_LAST)
            state_nxt = S_FRAME;
        end
      end
      S_FRAME: begin
        frame_end = 1'b1;
        state_nxt = S_SCAN;
      end
      default: state_nxt = S_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      r        <= '0;
    end else if (state == S_FRAME) begin
      slot_cnt <= '0;
      r        <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      r        <= r + RW'(1);
    end else begin
      slot_cnt <= slot_cnt + SW'(1);
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .cap_en   (cap_en),
    .cap_row  (r),
    .cap_bits (~col_sync),
    .frame_end(frame_end),
    .key_state(ks),
    .key_pulse(kp),
    .key_any  (kany),
    .key_code (kcode)
  );

  // Reset is synchronous, so the registers only clear
  // at the next edge; mask outputs so the IRQ lines
  // and row pins are quiet for the whole reset cycle.
  assign row       = rst ? '1 : row_drv;
  assign key_state = rst ? '0 : ks;
  assign key_pulse = rst ? '0 : kp;
  assign key_any   = rst ? 1'b0 : kany;
  assign key_code  = rst ? '0 : kcode;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce (SCAN_DIV=4, DEBOUNCE_FRAMES=3).
module tb_keypad_scan_debounce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key_state;
  logic [15:0] key_pulse;
  logic        key_any;
  logic [3:0]  key_code;
  logic [15:0] keys = 16'h0;

  int checks   = 0;
  int failures = 0;

  keypad_scan_debounce #(
    .SCAN_DIV       (4),
    .DEBOUNCE_FRAMES(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .key_state(key_state),
    .key_pulse(key_pulse),
    .key_any  (key_any),
    .key_code (key_code)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its column low
  // while its row is driven low.
  always_comb begin
    col = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[r*4+c] && !row[r])
          col[c] = 1'b0;
  end

  typedef struct {
    int          cyc;
    logic [3:0]  row;
    logic [15:0] st;
    logic [15:0] pl;
    logic        any;
    logic [3:0]  code;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, logic [3:0] r,
                         logic [15:0] st, logic [15:0] pl,
                         logic any, logic [3:0] code);
    chk({nm, ".row"}, row, r);
    chk({nm, ".state"}, key_state, st);
    chk({nm, ".pulse"}, key_pulse, pl);
    chk({nm, ".any"}, key_any, any);
    chk({nm, ".code"}, key_code, code);
  endtask

  // Holds rst for n edges, checking outputs in each
  // reset cycle; returns at the start of cycle 0.
  task automatic do_reset(int n);
    rst  = 1'b1;
    keys = 16'h0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk_out("rst", 4'hF, 16'h0, 16'h0, 1'b0, 4'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  int          idx;
  int          np;
  int          bad_p;
  int          bad_s;
  logic [3:0]  exp_row;

  initial begin
    tbl[0]  = '{0,   4'hE, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[1]  = '{3,   4'hE, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[2]  = '{4,   4'hD, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[3]  = '{8,   4'hB, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[4]  = '{12,  4'h7, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[5]  = '{15,  4'h7, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[6]  = '{16,  4'hF, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[7]  = '{17,  4'hE, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[8]  = '{33,  4'hF, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[9]  = '{50,  4'hF, 16'h0,  16'h0,  1'b0, 4'd0};
    tbl[10] = '{51,  4'hE, 16'h20, 16'h20, 1'b1, 4'd5};
    tbl[11] = '{52,  4'hE, 16'h20, 16'h0,  1'b0, 4'd0};
    tbl[12] = '{67,  4'hF, 16'h20, 16'h0,  1'b0, 4'd0};
    tbl[13] = '{68,  4'hE, 16'h20, 16'h0,  1'b0, 4'd0};
    tbl[14] = '{85,  4'hE, 16'h20, 16'h0,  1'b0, 4'd0};
    tbl[15] = '{239, 4'hE, 16'h20, 16'h0,  1'b0, 4'd0};

    // Row sequence and single press of key 5.
    do_reset(3);
    keys = 16'h0020;
    idx  = 0;
    np   = 0;
    for (int c = 0; c < 240; c++) begin
      @(negedge clk);
      exp_row = (c % 17 == 16) ? 4'hF
              : ~(4'b0001 << ((c % 17) / 4));
      if (c < 34)
        chk("t1_row_seq", row, exp_row);
      if (idx < NV && tbl[idx].cyc == c) begin
        chk_out("t1_vec", tbl[idx].row, tbl[idx].st,
                tbl[idx].pl, tbl[idx].any, tbl[idx].code);
        idx++;
      end
      if (key_pulse != 16'h0)
        np++;
      @(posedge clk);
      #1;
    end
    chk("t1_vecs_seen", idx, NV);
    chk("t1_pulse_count", np, 1);

    // Key 5 bouncing once per frame never commits.
    do_reset(3);
    keys  = 16'h0020;
    bad_p = 0;
    bad_s = 0;
    for (int c = 0; c < 187; c++) begin
      @(negedge clk);
      if (key_pulse != 16'h0) bad_p++;
      if (key_state != 16'h0) bad_s++;
      @(posedge clk);
      #1;
      if (c + 1 < 102 && (c + 1) % 17 == 0)
        keys = keys ^ 16'h0020;
      if (c + 1 == 102)
        keys = 16'h0;
    end
    chk("t2_bounce_pulses", bad_p, 0);
    chk("t2_bounce_state", bad_s, 0);

    // Hold, release (no pulse), re-press.
    do_reset(3);
    keys = 16'h0020;
    np   = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 51)
        chk_out("t3_press", 4'hE, 16'h20, 16'h20, 1'b1, 4'd5);
      if (c == 118)
        chk("t3_held_before_rel", key_state, 16'h20);
      if (c == 119)
        chk("t3_released", key_state, 16'h0);
      if (c > 51 && c < 187 && key_pulse != 16'h0)
        np++;
      if (c == 187)
        chk_out("t3_repress", 4'hE, 16'h20, 16'h20, 1'b1, 4'd5);
      @(posedge clk);
      #1;
      if (c + 1 == 68)  keys = 16'h0;
      if (c + 1 == 136) keys = 16'h0020;
    end
    chk("t3_release_pulses", np, 0);

    // Keys 0 and 15 committed together.
    do_reset(3);
    keys = 16'h8001;
    np   = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (key_pulse != 16'h0) np++;
      if (c == 50) chk("t4_pre", key_pulse, 16'h0);
      if (c == 51)
        chk_out("t4_dual", 4'hE, 16'h8001, 16'h8001, 1'b1, 4'd0);
      if (c == 52) chk("t4_post", key_pulse, 16'h0);
      @(posedge clk);
      #1;
    end
    chk("t4_pulse_count", np, 1);

    // Key 3 held, one-cycle reset mid frame 2.
    do_reset(3);
    keys = 16'h0008;
    np   = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (key_pulse != 16'h0) np++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_out("t5_in_rst", 4'hF, 16'h0, 16'h0, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (key_pulse != 16'h0) np++;
      if (c == 0)
        chk_out("t5_after_rst", 4'hE, 16'h0, 16'h0, 1'b0, 4'd0);
      if (c == 50) chk("t5_pre", key_pulse, 16'h0);
      if (c == 51)
        chk_out("t5_press", 4'hE, 16'h8, 16'h8, 1'b1, 4'd3);
      if (c == 52) chk("t5_post", key_pulse, 16'h0);
      @(posedge clk);
      #1;
    end
    chk("t5_pulse_count", np, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
